// File: rtl/ray_pkg.sv
// Shared types and constants for the ray-intersection datapath (dot, cross and t-divide stages).
package ray_pkg;

    typedef logic signed [31:0] fix_t;

    localparam fix_t FIX_MAX    = 32'sh7FFF_FFFF;
    localparam fix_t FIX_MIN    = 32'sh8000_0000;
    localparam int   Q_BITS_DEF = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_FIX   = 2'd2,
        S_WRITE = 2'd3
    } ray_t_state_e;

    // 33-bit magnitude so that -2^31 maps to +2^31 without overflow.
    function automatic logic [32:0] fix_mag(input fix_t v);
        logic [32:0] ext_v;
        ext_v = {v[31], v};
        if (v[31]) begin
            return 33'd0 - ext_v;
        end else begin
            return ext_v;
        end
    endfunction

endpackage

// File: rtl/udiv_iter.sv
// udiv_iter: unsigned restoring divider, one quotient bit per cycle, MSB first.
// done is asserted combinationally during the final step; quotient is valid the cycle after.
module udiv_iter #(
    parameter int W  = 42,
    parameter int DW = 33
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  quotient
);

    localparam int               CNT_W    = 6;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [W-1:0]     quo_r;
    logic [DW-1:0]    rem_r;
    logic [DW-1:0]    dsr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [DW:0]      trial_s;
    logic [DW:0]      diff_s;
    logic             fits_s;
    logic             done_s;

    // Trial subtraction: a clear top bit of the difference means the divisor fits.
    always_comb begin
        trial_s = {rem_r, quo_r[W-1]};
        diff_s  = trial_s - {1'b0, dsr_r};
        fits_s  = ~diff_s[DW];
        done_s  = busy_r && (cnt_r == LAST_CNT);
    end

    // Iteration registers; quo_r shifts the dividend out and the quotient bits in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            quo_r  <= {W{1'b0}};
            rem_r  <= {DW{1'b0}};
            dsr_r  <= {DW{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
        end else if (start) begin
            quo_r  <= dividend;
            rem_r  <= {DW{1'b0}};
            dsr_r  <= divisor;
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b1;
        end else if (busy_r) begin
            rem_r  <= fits_s ? diff_s[DW-1:0] : trial_s[DW-1:0];
            quo_r  <= {quo_r[W-2:0], fits_s};
            cnt_r  <= cnt_r + CNT_ONE;
            busy_r <= !done_s;
        end else begin
            quo_r  <= quo_r;
            rem_r  <= rem_r;
            dsr_r  <= dsr_r;
            cnt_r  <= cnt_r;
            busy_r <= busy_r;
        end
    end

    assign busy     = busy_r;
    assign done     = done_s;
    assign quotient = quo_r;

endmodule

// File: rtl/ray_t_div.sv
// ray_t_div: ray-plane distance t = num / den in signed fixed point, FIFO in / FIFO out.
// Build macro RAY_T_TMIN_CULL_EN: hit requires t >= T_MIN instead of t > 0.
module ray_t_div
    import ray_pkg::*;
#(
    parameter int Q_BITS = Q_BITS_DEF,
    parameter int T_MIN  = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [31:0] num,
    input  logic               num_empty,
    output logic               num_rd_en,
    input  logic signed [31:0] den,
    input  logic               den_empty,
    output logic               den_rd_en,
    output logic signed [31:0] t,
    output logic               hit,
    input  logic               out_full,
    output logic               out_wr_en
);

    localparam int W = 32 + Q_BITS;

`ifdef RAY_T_TMIN_CULL_EN
    localparam bit CULL_EN = 1'b1;
`else
    localparam bit CULL_EN = 1'b0;
`endif

    // t > 0 is the same test as t >= 1 on raw Q values.
    localparam fix_t         HIT_MIN = CULL_EN ? fix_t'(T_MIN) : 32'sd1;
    localparam logic [W-1:0] POS_LIM = {{(W-32){1'b0}}, 32'h7FFF_FFFF};
    localparam logic [W-1:0] NEG_LIM = {{(W-32){1'b0}}, 32'h8000_0000};

    ray_t_state_e state_r;
    ray_t_state_e state_nx_s;
    logic         sign_r;
    fix_t         t_r;
    logic         hit_r;
    logic         den_zero_s;
    logic         div_start_s;
    logic         div_busy_s;
    logic         div_done_s;
    logic [32:0]  num_mag_s;
    logic [32:0]  den_mag_s;
    logic [W-1:0] dividend_s;
    logic [W-1:0] quot_s;
    fix_t         t_calc_s;
    logic         hit_calc_s;

    assign den_zero_s = (den == 32'sd0);
    assign num_mag_s  = fix_mag(num);
    assign den_mag_s  = fix_mag(den);
    assign dividend_s = W'({num_mag_s, {Q_BITS{1'b0}}});

    udiv_iter #(
        .W  (W),
        .DW (33)
    ) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start_s),
        .dividend (dividend_s),
        .divisor  (den_mag_s),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (quot_s)
    );

    // Handshake FSM: pops both FIFOs together, one pair in flight; all strobes low in reset.
    always_comb begin
        state_nx_s  = state_r;
        num_rd_en   = 1'b0;
        den_rd_en   = 1'b0;
        out_wr_en   = 1'b0;
        div_start_s = 1'b0;
        if (!reset) begin
            state_nx_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!num_empty && !den_empty) begin
                        num_rd_en = 1'b1;
                        den_rd_en = 1'b1;
                        if (den_zero_s) begin
                            state_nx_s = S_WRITE;
                        end else begin
                            div_start_s = 1'b1;
                            state_nx_s  = S_DIV;
                        end
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end
                S_DIV: begin
                    if (div_done_s) begin
                        state_nx_s = S_FIX;
                    end else if (div_busy_s) begin
                        state_nx_s = S_DIV;
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end
                S_FIX: begin
                    state_nx_s = S_WRITE;
                end
                S_WRITE: begin
                    if (!out_full) begin
                        out_wr_en  = 1'b1;
                        state_nx_s = S_IDLE;
                    end else begin
                        state_nx_s = S_WRITE;
                    end
                end
                default: begin
                    state_nx_s = S_IDLE;
                end
            endcase
        end
    end

    // Sign restore with saturation; the quotient is already truncated toward zero.
    always_comb begin
        t_calc_s = FIX_MAX;
        if (sign_r) begin
            if (quot_s > NEG_LIM) begin
                t_calc_s = FIX_MIN;
            end else begin
                t_calc_s = fix_t'(32'd0 - quot_s[31:0]);
            end
        end else begin
            if (quot_s > POS_LIM) begin
                t_calc_s = FIX_MAX;
            end else begin
                t_calc_s = fix_t'(quot_s[31:0]);
            end
        end
        hit_calc_s = (t_calc_s >= HIT_MIN);
    end

    // State, sign and result registers; t/hit move only on a result-capture edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            sign_r  <= 1'b0;
            t_r     <= 32'sd0;
            hit_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (div_start_s) begin
                sign_r <= num[31] ^ den[31];
            end else begin
                sign_r <= sign_r;
            end
            if (num_rd_en && den_zero_s) begin
                t_r   <= FIX_MAX;
                hit_r <= 1'b0;
            end else if (state_r == S_FIX) begin
                t_r   <= t_calc_s;
                hit_r <= hit_calc_s;
            end else begin
                t_r   <= t_r;
                hit_r <= hit_r;
            end
        end
    end

    assign t   = t_r;
    assign hit = hit_r;

endmodule

// File: tb/tb_ray_t_div.sv
// Self-checking bench for ray_t_div: vector table plus out_full and mid-divide reset sequences.
`timescale 1ns/1ps
module tb_ray_t_div;

    localparam int TMIN_TB = 1024;

    typedef struct packed {
        logic [31:0] t;
        logic        hit;
    } exp_rec_t;

    typedef struct {
        logic [31:0] n;
        logic [31:0] d;
        logic [31:0] t;
        logic        hit_def;
        logic        hit_cull;
        int          lat;
    } vec_t;

    logic               clock;
    logic               reset;
    logic signed [31:0] num;
    logic               num_empty;
    logic               num_rd_en;
    logic signed [31:0] den;
    logic               den_empty;
    logic               den_rd_en;
    logic signed [31:0] t;
    logic               hit;
    logic               out_full;
    logic               out_wr_en;

    int       n_checks = 0;
    int       n_fail   = 0;
    int       cyc      = 0;
    int       wr_count = 0;
    int       last_wr_cyc = 0;
    exp_rec_t exp_q[$];
    vec_t     vecs[17];

    ray_t_div #(
        .Q_BITS (10),
        .T_MIN  (TMIN_TB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .num       (num),
        .num_empty (num_empty),
        .num_rd_en (num_rd_en),
        .den       (den),
        .den_empty (den_empty),
        .den_rd_en (den_rd_en),
        .t         (t),
        .hit       (hit),
        .out_full  (out_full),
        .out_wr_en (out_wr_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Output monitor / scoreboard, sampling 1 ns after the falling edge.
    initial begin
        exp_rec_t e;
        forever begin
            @(negedge clock);
            #1;
            if (out_wr_en) begin
                wr_count++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("t", t, e.t);
                    check("hit", {31'd0, hit}, {31'd0, e.hit});
                end
            end
            if (num_rd_en || den_rd_en) begin
                check("rd_en_pair", {31'd0, num_rd_en}, {31'd0, den_rd_en});
                check("pop_gating", {31'd0, num_empty | den_empty | !reset}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_pop(output int pop_cyc);
        int k;
        k = 0;
        #1;
        while (!num_rd_en && k < 200) begin
            @(negedge clock);
            #1;
            k++;
        end
        check("pop_seen", {31'd0, num_rd_en}, 32'd1);
        pop_cyc = cyc;
    endtask

    task automatic wait_write(input int wr0);
        int k;
        k = 0;
        #2;
        while (wr_count == wr0 && k < 200) begin
            @(negedge clock);
            #2;
            k++;
        end
        check("write_seen", 32'(wr_count - wr0), 32'd1);
    endtask

    task automatic run_pair(input logic [31:0] n, input logic [31:0] d,
                            input logic [31:0] t_exp, input logic h_exp, input int lat_exp);
        int pop_cyc;
        int wr0;
        @(negedge clock);
        num = n;
        den = d;
        num_empty = 1'b0;
        den_empty = 1'b0;
        exp_q.push_back(exp_rec_t'{t_exp, h_exp});
        wait_pop(pop_cyc);
        wr0 = wr_count;
        @(negedge clock);
        num_empty = 1'b1;
        den_empty = 1'b1;
        wait_write(wr0);
        check("latency", 32'(last_wr_cyc - pop_cyc), 32'(lat_exp));
        @(negedge clock);
        #2;
        check("wr_single_pulse", {31'd0, out_wr_en}, 32'd0);
    endtask

    initial begin
        int pop_cyc;
        int wr0;
        int w_cyc;
        int k;
        logic h_sel;

        //            num           den           t             def   cull  lat
        vecs[0]  = '{32'd2048,     32'd1024,     32'd2048,     1'b1, 1'b1, 44};
        vecs[1]  = '{32'hFFFFFC00, 32'd2048,     32'hFFFFFE00, 1'b0, 1'b0, 44};
        vecs[2]  = '{32'hFFFFFFFD, 32'd2048,     32'hFFFFFFFF, 1'b0, 1'b0, 44};
        vecs[3]  = '{32'd5000,     32'd0,        32'h7FFFFFFF, 1'b0, 1'b0, 1};
        vecs[4]  = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b1, 1'b1, 44};
        vecs[5]  = '{32'd512,      32'd1024,     32'd512,      1'b1, 1'b0, 44};
        vecs[6]  = '{32'h80000000, 32'd1,        32'h80000000, 1'b0, 1'b0, 44};
        vecs[7]  = '{32'd1,        32'd3,        32'd341,      1'b1, 1'b0, 44};
        vecs[8]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3584,     1'b1, 1'b1, 44};
        vecs[9]  = '{32'd0,        32'd5,        32'd0,        1'b0, 1'b0, 44};
        vecs[10] = '{32'd1,        32'd1024,     32'd1,        1'b1, 1'b0, 44};
        vecs[11] = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 44};
        vecs[12] = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b0, 44};
        vecs[13] = '{32'h7FFFFFFF, 32'd1024,     32'h7FFFFFFF, 1'b1, 1'b1, 44};
        vecs[14] = '{32'h80000000, 32'hFFFFFC00, 32'h7FFFFFFF, 1'b1, 1'b1, 44};
        vecs[15] = '{32'd0,        32'd0,        32'h7FFFFFFF, 1'b0, 1'b0, 1};
        vecs[16] = '{32'h80000000, 32'd1024,     32'h80000000, 1'b0, 1'b0, 44};

        // Reset with both FIFOs non-empty: nothing may be popped.
        reset = 1'b0;
        num = 32'sd1;
        den = 32'sd1;
        num_empty = 1'b0;
        den_empty = 1'b0;
        out_full = 1'b0;
        repeat (3) @(negedge clock);
        #2;
        check("reset_num_rd_en", {31'd0, num_rd_en}, 32'd0);
        check("reset_den_rd_en", {31'd0, den_rd_en}, 32'd0);
        check("reset_out_wr_en", {31'd0, out_wr_en}, 32'd0);
        check("reset_t", t, 32'd0);
        check("reset_hit", {31'd0, hit}, 32'd0);
        @(negedge clock);
        num_empty = 1'b1;
        den_empty = 1'b1;
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
`ifdef RAY_T_TMIN_CULL_EN
            h_sel = vecs[i].hit_cull;
`else
            h_sel = vecs[i].hit_def;
`endif
            run_pair(vecs[i].n, vecs[i].d, vecs[i].t, h_sel, vecs[i].lat);
        end

        // Output FIFO full for 10 cycles in S_WRITE with a second pair waiting.
        out_full = 1'b1;
        @(negedge clock);
        num = 32'sd3072;
        den = 32'sd1024;
        num_empty = 1'b0;
        den_empty = 1'b0;
        exp_q.push_back(exp_rec_t'{32'd3072, 1'b1});
        wait_pop(pop_cyc);
        wr0 = wr_count;
        @(negedge clock);
        num = -32'sd4096;
        den = 32'sd1024;
        exp_q.push_back(exp_rec_t'{32'hFFFFF000, 1'b0});
        while (cyc < pop_cyc + 44) @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clock);
            #2;
            check("full_no_write", {31'd0, out_wr_en}, 32'd0);
            check("full_no_pop", {31'd0, num_rd_en}, 32'd0);
            check("full_t_stable", t, 32'd3072);
        end
        @(negedge clock);
        out_full = 1'b0;
        #2;
        check("full_release_push", 32'(wr_count - wr0), 32'd1);
        check("no_pop_during_write", {31'd0, num_rd_en}, 32'd0);
        w_cyc = last_wr_cyc;
        check("full_write_cycle", 32'(w_cyc - pop_cyc), 32'd54);
        k = 0;
        @(negedge clock);
        #2;
        while (!num_rd_en && k < 20) begin
            @(negedge clock);
            #2;
            k++;
        end
        check("pop_after_write", 32'(cyc - w_cyc), 32'd1);
        pop_cyc = cyc;
        wr0 = wr_count;
        @(negedge clock);
        num_empty = 1'b1;
        den_empty = 1'b1;
        wait_write(wr0);
        check("second_latency", 32'(last_wr_cyc - pop_cyc), 32'd44);

        // One FIFO empty: no pop for 20 cycles, then reset in the middle of a divide.
        @(negedge clock);
        num = 32'sd4096;
        den = 32'sd1024;
        num_empty = 1'b0;
        den_empty = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #2;
            check("half_empty_num_rd", {31'd0, num_rd_en}, 32'd0);
            check("half_empty_den_rd", {31'd0, den_rd_en}, 32'd0);
            @(negedge clock);
        end
        den_empty = 1'b0;
        wait_pop(pop_cyc);
        wr0 = wr_count;
        @(negedge clock);
        num_empty = 1'b1;
        den_empty = 1'b1;
        while (cyc < pop_cyc + 20) @(negedge clock);
        reset = 1'b0;
        num_empty = 1'b0;
        den_empty = 1'b0;
        #2;
        check("midreset_t", t, 32'd0);
        check("midreset_hit", {31'd0, hit}, 32'd0);
        check("midreset_rd_en", {31'd0, num_rd_en | den_rd_en}, 32'd0);
        check("midreset_wr_en", {31'd0, out_wr_en}, 32'd0);
        @(negedge clock);
        #2;
        check("midreset_hold_rd_en", {31'd0, num_rd_en | den_rd_en}, 32'd0);
        @(negedge clock);
        num_empty = 1'b1;
        den_empty = 1'b1;
        reset = 1'b1;
        repeat (60) @(negedge clock);
        #2;
        check("midreset_no_write", 32'(wr_count - wr0), 32'd0);
        run_pair(32'd4096, 32'd1024, 32'd4096, 1'b1, 44);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
